// File: rtl/mem_definitions.sv
// rtl/mem_definitions.sv - shared IO-space constants and bus controller state encoding.
package mem_definitions;

  localparam logic [23:0] IO_MEM_SPACE = 24'h400000;
  localparam logic [31:0] IO_ERR_DATA  = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } io_state_t;

endpackage

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - CPU-to-peripheral IO bus bridge, four one-hot slots.
// Define IO_BUS_TIMEOUT_EN to bound peripheral wait to TIMEOUT_CYCLES.
module io_bus_ctrl
  import mem_definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      b_addr_i,
  input  logic [31:0]      b_wdata_i,
  input  logic             b_read_i,
  input  logic             b_write_i,
  output logic [31:0]      b_rdata_o,
  output logic             b_ack_o,
  output logic             bus_err_o,
  output logic [3:0]       p_req_o,
  output logic             p_we_o,
  output logic [5:0]       p_addr_o,
  output logic [31:0]      p_wdata_o,
  input  logic [3:0][31:0] p_rdata_i,
  input  logic [3:0]       p_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("io_bus_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  io_state_t   state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        io_hit;

  assign io_hit = (b_read_i | b_write_i) && (b_addr_i[31:8] == IO_MEM_SPACE);

`ifdef IO_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef IO_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (io_hit) begin
          state_d = REQ;
          slot_d  = b_addr_i[7:6];
          addr_d  = b_addr_i[5:0];
          wdata_d = b_wdata_i;
          // Simultaneous read and write resolves to a write.
          we_d    = b_write_i;
`ifdef IO_BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      REQ: begin
        if (p_ack_i[slot_q]) begin
          state_d = ACK;
          rdata_d = we_q ? 32'd0 : p_rdata_i[slot_q];
        end
`ifdef IO_BUS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ACK;
          rdata_d = IO_ERR_DATA;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err_o = err_q;
`else
  assign bus_err_o = 1'b0;
`endif

  assign p_req_o   = (state_q == REQ) ? (4'b0001 << slot_q) : 4'b0000;
  assign b_ack_o   = (state_q == ACK);
  assign b_rdata_o = rdata_q;
  assign p_we_o    = we_q;
  assign p_addr_o  = addr_q;
  assign p_wdata_o = wdata_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - directed self-checking bench for io_bus_ctrl.
// Timeout scenario runs only when IO_BUS_TIMEOUT_EN is defined.
module tb_io_bus_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      b_addr_i, b_wdata_i;
  logic             b_read_i, b_write_i;
  logic [31:0]      b_rdata_o;
  logic             b_ack_o, bus_err_o;
  logic [3:0]       p_req_o;
  logic             p_we_o;
  logic [5:0]       p_addr_o;
  logic [31:0]      p_wdata_o;
  logic [3:0][31:0] p_rdata_i;
  logic [3:0]       p_ack_i;

  int checks   = 0;
  int failures = 0;

  io_bus_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_read_i(b_read_i), .b_write_i(b_write_i),
    .b_rdata_o(b_rdata_o), .b_ack_o(b_ack_o), .bus_err_o(bus_err_o),
    .p_req_o(p_req_o), .p_we_o(p_we_o), .p_addr_o(p_addr_o),
    .p_wdata_o(p_wdata_o), .p_rdata_i(p_rdata_i), .p_ack_i(p_ack_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b_addr_i = '0; b_wdata_i = '0; b_read_i = 0; b_write_i = 0;
    p_rdata_i = '0; p_ack_i = '0;
    step(); step();
    @(negedge clk);
    checks++; if (p_req_o !== 4'b0000) begin failures++; $display("FAIL reset_p_req got=%b exp=0000", p_req_o); end
    checks++; if (b_ack_o !== 1'b0) begin failures++; $display("FAIL reset_b_ack got=%b exp=0", b_ack_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err_o); end
    checks++; if (b_rdata_o !== 32'd0) begin failures++; $display("FAIL reset_b_rdata got=%h exp=0", b_rdata_o); end
    checks++; if ({p_we_o, p_addr_o, p_wdata_o} !== 39'd0) begin failures++;
      $display("FAIL reset_p_regs got we=%b addr=%h wdata=%h exp all 0", p_we_o, p_addr_o, p_wdata_o); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    step();
    b_addr_i = 32'h40000084; b_read_i = 1'b1; p_ack_i = 4'b0000;
    p_rdata_i = {32'hCCCC0003, 32'h12345678, 32'hBBBB0001, 32'hAAAA0000};
    @(negedge clk);
    checks++; if (p_req_o !== 4'b0000) begin failures++; $display("FAIL rd_cycleN_p_req got=%b exp=0000", p_req_o); end
    step();
    p_ack_i = 4'b0100;
    @(negedge clk);
    checks++; if (p_req_o !== 4'b0100) begin failures++; $display("FAIL rd_p_req got=%b exp=0100", p_req_o); end
    checks++; if (p_addr_o !== 6'h04) begin failures++; $display("FAIL rd_p_addr got=%h exp=04", p_addr_o); end
    checks++; if (p_we_o !== 1'b0) begin failures++; $display("FAIL rd_p_we got=%b exp=0", p_we_o); end
    checks++; if (b_ack_o !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%b exp=0", b_ack_o); end
    step();
    p_ack_i = 4'b0000; b_read_i = 1'b0;
    @(negedge clk);
    checks++; if (b_ack_o !== 1'b1) begin failures++; $display("FAIL rd_ack_N2 got=%b exp=1", b_ack_o); end
    checks++; if (b_rdata_o !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", b_rdata_o); end
    checks++; if (p_req_o !== 4'b0000) begin failures++; $display("FAIL rd_ack_p_req got=%b exp=0000", p_req_o); end
    step();
    @(negedge clk);
    checks++; if (b_ack_o !== 1'b0) begin failures++; $display("FAIL rd_ack_width got=%b exp=0", b_ack_o); end
    checks++; if (b_rdata_o !== 32'h12345678) begin failures++; $display("FAIL rd_data_hold got=%h exp=12345678", b_rdata_o); end
  endtask

  task automatic test_write_wait();
    int acks = 0;
    step();
    // Both read and write asserted: must be a write.
    b_addr_i = 32'h400000C0; b_wdata_i = 32'hA5A5A5A5; b_write_i = 1'b1; b_read_i = 1'b1;
    p_rdata_i[3] = 32'hFFFF0000;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step();
      b_write_i = 1'b0; b_read_i = 1'b0; b_wdata_i = 32'h0;
      p_ack_i = (i == 3) ? 4'b1000 : 4'b0111;
      @(negedge clk);
      checks++; if (p_req_o !== 4'b1000) begin failures++; $display("FAIL wr_p_req cyc=%0d got=%b exp=1000", i, p_req_o); end
      checks++; if (p_we_o !== 1'b1) begin failures++; $display("FAIL wr_p_we cyc=%0d got=%b exp=1", i, p_we_o); end
      checks++; if (p_wdata_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL wr_p_wdata cyc=%0d got=%h exp=a5a5a5a5", i, p_wdata_o); end
      checks++; if (p_addr_o !== 6'h00) begin failures++; $display("FAIL wr_p_addr cyc=%0d got=%h exp=00", i, p_addr_o); end
      if (b_ack_o === 1'b1) acks++;
    end
    step();
    p_ack_i = 4'b0000;
    @(negedge clk);
    checks++; if (b_ack_o !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", b_ack_o); end
    checks++; if (b_rdata_o !== 32'd0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", b_rdata_o); end
    if (b_ack_o === 1'b1) acks++;
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      if (b_ack_o === 1'b1) acks++;
    end
    checks++; if (acks != 1) begin failures++; $display("FAIL wr_ack_pulses got=%0d exp=1", acks); end
  endtask

  task automatic test_non_io();
    bit seen_req = 0, seen_ack = 0;
    step();
    b_addr_i = 32'h00001000; b_read_i = 1'b1; p_ack_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step(); @(negedge clk);
      if (p_req_o !== 4'b0000) seen_req = 1;
      if (b_ack_o !== 1'b0) seen_ack = 1;
    end
    checks++; if (seen_req) begin failures++; $display("FAIL nonio_p_req got=1 exp=0"); end
    checks++; if (seen_ack) begin failures++; $display("FAIL nonio_ack got=1 exp=0"); end
    b_read_i = 1'b0; p_ack_i = 4'b0000;
  endtask

  task automatic test_reset_mid_req();
    bit bad = 0;
    step();
    b_addr_i = 32'h40000004; b_read_i = 1'b1; p_ack_i = 4'b0000;
    step();
    b_read_i = 1'b0;
    @(negedge clk);
    checks++; if (p_req_o !== 4'b0001) begin failures++; $display("FAIL rst_pre_p_req got=%b exp=0001", p_req_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (p_req_o !== 4'b0000) begin failures++; $display("FAIL rst_async_p_req got=%b exp=0000", p_req_o); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      if (b_ack_o !== 1'b0 || p_req_o !== 4'b0000) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL rst_aborted_ack got=activity exp=none"); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_ack;
    logic [6:0] exp_req;
    exp_ack = 7'b0100100;
    exp_req = 7'b0010010;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        b_addr_i = 32'h40000000; b_read_i = 1'b1; p_ack_i = 4'b0001;
        p_rdata_i[0] = 32'h11111111;
      end
      if (k == 3) p_rdata_i[0] = 32'h22222222;
      if (k == 5) begin b_read_i = 1'b0; p_ack_i = 4'b0000; end
      @(negedge clk);
      checks++; if (b_ack_o !== exp_ack[k]) begin failures++; $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, b_ack_o, exp_ack[k]); end
      checks++; if (p_req_o !== (exp_req[k] ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL b2b_p_req k=%0d got=%b", k, p_req_o); end
      if (k == 2) begin
        checks++; if (b_rdata_o !== 32'h11111111) begin failures++; $display("FAIL b2b_data1 got=%h exp=11111111", b_rdata_o); end
      end
      if (k == 5) begin
        checks++; if (b_rdata_o !== 32'h22222222) begin failures++; $display("FAIL b2b_data2 got=%h exp=22222222", b_rdata_o); end
      end
    end
  endtask

`ifdef IO_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit got = 0;
    step();
    b_addr_i = 32'h40000040; b_read_i = 1'b1; p_ack_i = 4'b1101;
    @(negedge clk);
    while (!got && n < 40) begin
      step();
      b_read_i = 1'b0;
      @(negedge clk);
      n++;
      if (b_ack_o === 1'b1) got = 1;
    end
    checks++; if (!got || n != 17) begin failures++; $display("FAIL to_latency got=%0d exp=17 acked=%0d", n, got); end
    checks++; if (bus_err_o !== 1'b1) begin failures++; $display("FAIL to_bus_err got=%b exp=1", bus_err_o); end
    checks++; if (b_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL to_rdata got=%h exp=deadbeef", b_rdata_o); end
    p_ack_i = 4'b0000;
    step(); @(negedge clk);
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL to_err_width got=%b exp=0", bus_err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_non_io();
    test_reset_mid_req();
    test_back_to_back();
`ifdef IO_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
